// File: rtl/fir_filter2_pkg.sv
// rtl/fir_filter2_pkg.sv - fixed sizes, reset constants and types for the four-tap FIR
package fir_filter2_pkg;

   localparam int NTAPS    = 4;
   localparam int SAMPLE_W = 8;
   localparam int COEF_W   = 8;
   localparam int PROD_W   = SAMPLE_W + COEF_W;
   localparam int ACC_W    = 18;
   localparam int SHIFT    = 6;

   localparam logic signed [COEF_W-1:0] COEF_RST = 8'sd16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [COEF_W-1:0]   coef_t;
   typedef logic signed [PROD_W-1:0]   prod_t;
   typedef logic signed [ACC_W-1:0]    acc_t;

   // Output range of the scaled result before it is narrowed to a sample.
   localparam acc_t Y_MAX = 18'sd127;
   localparam acc_t Y_MIN = -18'sd128;

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - combinational 4-tap MAC, >>>6 scaling, FIR_SAT_EN selects clamp or wrap
module fir_mac
   import fir_filter2_pkg::*;
(
   input  sample_t    taps  [NTAPS],
   input  coef_t      coefs [NTAPS],
   output sample_t    y,
   output logic       sat
);

   prod_t prod;
   acc_t  acc;
   acc_t  s;

   // Full-precision sum of products; 18 bits cannot overflow for four 8x8 products.
   always_comb begin
      prod = '0;
      acc  = '0;
      for (int k = 0; k < NTAPS; k++) begin
         prod = taps[k] * coefs[k];
         acc  = acc + acc_t'(prod);
      end
   end

   // Arithmetic shift keeps the sign, so truncation is toward minus infinity.
   assign s = acc >>> SHIFT;

`ifdef FIR_SAT_EN
   // Clamp the scaled value into the signed 8-bit range and flag when that happens.
   always_comb begin
      y   = sample_t'(s);
      sat = 1'b0;
      if (s > Y_MAX) begin
         y   = sample_t'(Y_MAX);
         sat = 1'b1;
      end else if (s < Y_MIN) begin
         y   = sample_t'(Y_MIN);
         sat = 1'b1;
      end
   end
`else
   logic unused_s_hi;

   // Two's-complement wrap: keep the low byte, never report saturation.
   always_comb begin
      y   = sample_t'(s);
      sat = 1'b0;
   end

   assign unused_s_hi = ^s[ACC_W-1:SAMPLE_W];
`endif

endmodule

// File: rtl/fir_filter2.sv
// rtl/fir_filter2.sv - TinyTapeout four-tap programmable FIR top (optional FIR_SAT_EN)
module fir_filter2
   import fir_filter2_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   sample_t    x [NTAPS];
   coef_t      c [NTAPS];
   sample_t    y_mac;
   logic       sat_mac;
   sample_t    y_q;
   logic       sat_q;
   logic       pend_q;
   logic       out_valid_q;

   logic       in_valid;
   logic       coef_we;
   logic [1:0] coef_addr;
   logic       take_sample;
   logic       take_coef;
   logic       unused_ctrl;

   assign in_valid    = uio_in[0];
   assign coef_we     = uio_in[1];
   assign coef_addr   = uio_in[3:2];
   assign unused_ctrl = ^uio_in[7:4];

   assign take_sample = ena & in_valid;
   assign take_coef   = ena & coef_we;

   // Delay line shifts one place per accepted sample, newest sample in x[0].
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NTAPS; k++) x[k] <= '0;
      end else if (take_sample) begin
         x[0] <= sample_t'(ui_in);
         for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
      end
   end

   // Coefficient file; a write may share the edge and the ui_in byte with a sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NTAPS; k++) c[k] <= COEF_RST;
      end else if (take_coef) begin
         c[coef_addr] <= coef_t'(ui_in);
      end
   end

   fir_mac u_mac (
      .taps  (x),
      .coefs (c),
      .y     (y_mac),
      .sat   (sat_mac)
   );

   // One-cycle-late output load: the MAC sees the line and coefficients as they
   // stand after the accepting edge. Not gated by ena so a pending update completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         sat_q       <= 1'b0;
      end else begin
         pend_q      <= take_sample;
         out_valid_q <= pend_q;
         if (pend_q) begin
            y_q   <= y_mac;
            sat_q <= sat_mac;
         end
      end
   end

   assign uo_out  = y_q;
   assign uio_out = {2'b00, sat_q, out_valid_q, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_fir_filter2.sv
// tb/tb_fir_filter2.sv - directed and random checks of fir_filter2 against a behavioural model
module tb_fir_filter2;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int errors = 0;
   int checks = 0;

   int         mx [4];
   int         mc [4];
   logic       m_pend;
   logic [7:0] m_pend_y;
   logic       m_pend_sat;
   logic [7:0] m_y;
   logic       m_sat;
   logic       m_vld;

   fir_filter2 dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] y, input logic v);
      chk(tag, uo_out, y);
      chk({tag, "_valid"}, {7'b0, uio_out[4]}, {7'b0, v});
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 4; k++) begin
         mx[k] = 0;
         mc[k] = 16;
      end
      m_pend     = 1'b0;
      m_pend_y   = 8'h00;
      m_pend_sat = 1'b0;
      m_y        = 8'h00;
      m_sat      = 1'b0;
      m_vld      = 1'b0;
   endfunction

   function automatic void model_eval(output logic [7:0] y, output logic sat);
      int acc;
      int s;
      acc = 0;
      for (int k = 0; k < 4; k++) acc += mx[k] * mc[k];
      s = int'($floor(real'(acc) / 64.0));
`ifdef FIR_SAT_EN
      if (s > 127) begin
         y = 8'd127; sat = 1'b1;
      end else if (s < -128) begin
         y = 8'h80;  sat = 1'b1;
      end else begin
         y = 8'(s);  sat = 1'b0;
      end
`else
      y   = 8'(s);
      sat = 1'b0;
`endif
   endfunction

   task automatic cycle(input logic r, input logic e, input logic v, input logic we,
                        input logic [1:0] a, input logic [7:0] d);
      rst    = r;
      ena    = e;
      ui_in  = d;
      uio_in = {4'b0000, a, we, v};
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         m_vld = m_pend;
         if (m_pend) begin
            m_y   = m_pend_y;
            m_sat = m_pend_sat;
         end
         m_pend = e & v;
         if (e & v) begin
            mx[3] = mx[2];
            mx[2] = mx[1];
            mx[1] = mx[0];
            mx[0] = int'($signed(d));
         end
         if (e & we) mc[a] = int'($signed(d));
         if (m_pend) model_eval(m_pend_y, m_pend_sat);
      end
      #1;
      chk("model_y", uo_out, m_y);
      chk("model_status", uio_out, {2'b00, m_sat, m_vld, 4'b0000});
   endtask

   task automatic sample(input logic [7:0] d);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, d);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
   endtask

   task automatic wcoef(input logic [1:0] a, input logic [7:0] d);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, a, d);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
      model_reset();

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      chk("rst_y", uo_out, 8'h00);
      chk("rst_status", uio_out, 8'h00);
      chk("oe", uio_oe, 8'hF0);

      sample(8'd0);
      idle();
      chk_out("zero_in", 8'd0, 1'b1);

      sample(8'd64);
      sample(8'd0);  chk_out("imp0", 8'd16, 1'b1);
      sample(8'd0);  chk_out("imp1", 8'd16, 1'b1);
      sample(8'd0);  chk_out("imp2", 8'd16, 1'b1);
      sample(8'd0);  chk_out("imp3", 8'd16, 1'b1);
      idle();        chk_out("imp4", 8'd0, 1'b1);
      idle();        chk_out("imp_idle", 8'd0, 1'b0);

      sample(8'd100);
      sample(8'd100); chk_out("step0", 8'd25, 1'b1);
      sample(8'd100); chk_out("step1", 8'd50, 1'b1);
      sample(8'd100); chk_out("step2", 8'd75, 1'b1);
      idle();         chk_out("step3", 8'd100, 1'b1);

      wcoef(2'd0, 8'd64);
      wcoef(2'd1, 8'd0);
      wcoef(2'd2, 8'd0);
      wcoef(2'd3, 8'd0);
      sample(8'h80);
      idle();         chk_out("pass_neg", 8'h80, 1'b1);
      sample(8'd37);
      idle();         chk_out("pass_37", 8'd37, 1'b1);

      for (int k = 0; k < 4; k++) wcoef(2'(k), 8'd127);
      for (int k = 0; k < 4; k++) sample(8'd127);
      idle();
`ifdef FIR_SAT_EN
      chk_out("sat_y", 8'd127, 1'b1);
      chk("sat_flag", {7'b0, uio_out[5]}, 8'd1);
`else
      chk_out("wrap_y", 8'hF0, 1'b1);
      chk("wrap_flag", {7'b0, uio_out[5]}, 8'd0);
`endif

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h55);
      idle();         chk_out("gate_novalid", 8'd0, 1'b0);
      sample(8'd64);
      idle();         chk_out("gate_imp0", 8'd16, 1'b1);
      sample(8'd0);
      idle();         chk_out("gate_imp1", 8'd16, 1'b1);

      sample(8'd64);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      chk_out("ena_low_pending", 8'd32, 1'b1);

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 8'd64);
      idle();         chk_out("same_edge", 8'd64, 1'b1);

      sample(8'd50);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      chk_out("midrst", 8'd0, 1'b0);
      idle();         chk_out("midrst_drop", 8'd0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0),
               2'($urandom_range(0, 3)),
               8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fir_filter2.md
# fir_filter2

Four-tap programmable FIR filter for the TinyTapeout tile. It takes signed 8-bit samples on the dedicated inputs and stores four coefficients, which are loaded through the same input bus. It produces a scaled, saturated signed 8-bit result on the dedicated outputs. It is the top-level user block behind the TinyTapeout pin wrapper.

## Interface
- Parameters: none. All sizes are fixed constants in the package.
- `clk`  in  1  system clock; every register is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  tile enable. When low, sample strobes and coefficient writes are ignored and all state holds.
- `ui_in`  in  8  signed sample x, or signed coefficient data during a coefficient write.
- `uio_in`  in  8  control:
  - [0] `in_valid`
  - [1] `coef_we`
  - [3:2] `coef_addr`
  - [7:4] unused
- `uo_out`  out  8  signed filtered result y.
- `uio_out`  out  8  status:
  - [4] `out_valid`
  - [5] `sat` (saturation flag)
  - all other bits are 0.
- `uio_oe`  out  8  constant 8'hF0.

## Operation
- Delay line x0..x3 (signed 8-bit). On an edge with `ena & in_valid`: x3←x2, x2←x1, x1←x0, x0←ui_in.
- Coefficients c0..c3 (signed 8-bit). On an edge with `ena & coef_we`: c[coef_addr]←ui_in.
- A sample and a coefficient write may occur on the same edge. Both take effect, and ui_in supplies both values.
- MAC: acc = Σ ck·xk, full signed precision, 18-bit signed accumulator (no overflow is possible).
- Scaling: s = acc >>> 6 (arithmetic shift, truncates toward −∞).
- Saturation: s is clamped to [−128, 127]. `sat` = 1 when clamping occurred.
- y and `sat` are registered and hold until the next accepted sample.
- Reset values:
  - x0..x3 = 0
  - c0..c3 = 16, so the default response is a 4-sample moving average
  - uo_out = 0, out_valid = 0, sat = 0.

## Timing
- Sample accepted at edge E.
- At edge E+1, uo_out and `sat` load the result computed from the delay line and coefficients as they stand after edge E. A coefficient written at edge E is therefore used.
- At edge E+1, `out_valid` is set. It stays high for one cycle only, unless another sample was accepted at E+1.
- Back-to-back samples (in_valid held high): one output per cycle, latency 1 cycle, `out_valid` continuously high.
- `ena` low at edge E+1: the output register and `out_valid` still complete the pending update. Only new acceptances are blocked.
- `rst` has priority over all other inputs. Asserting it mid-stream clears the delay line, coefficients and outputs on that edge, and any pending output is discarded.

## Configuration
- `FIR_SAT_EN` defined: saturation as described above.
- `FIR_SAT_EN` undefined: y = s[7:0] (two's-complement wrap), and `sat` is tied to 0.

## Structure
- Package `fir_filter2_pkg`:
  - NTAPS = 4, SAMPLE_W = 8, COEF_W = 8, ACC_W = 18, SHIFT = 6, COEF_RST = 8'sd16
  - typedefs `sample_t`, `coef_t`, `acc_t`.
- Sub-module `fir_mac`: combinational 4-tap multiply-accumulate, plus the shift and optional saturation. It takes taps and coefficients and returns y and sat.
- The top holds the delay line, coefficient registers, output registers and pin mapping.

## Test plan
- Reset: rst high for 2 cycles → uo_out = 0, uio_out = 0, uio_oe = 8'hF0. Afterwards, input 0 → output 0.
- Impulse, default coefficients: samples 64, 0, 0, 0, 0 → outputs 16, 16, 16, 16, 0, each with a one-cycle `out_valid` pulse, 1 cycle after the sample.
- Step: four samples of 100 → outputs 25, 50, 75, 100.
- Coefficient load: c0 = 64, c1 = c2 = c3 = 0. Sample −128 → output −128 (pass-through). Sample 37 → output 37.
- Saturation: all c = 127, four samples of 127 → acc = 64516, s = 1008.
  - With `FIR_SAT_EN`: uo_out = 127, sat = 1.
  - Without it: uo_out = 8'hF0, sat = 0.
- Enable gating: ena = 0 with in_valid = 1 and coef_we = 1 → no `out_valid`, and the delay line and coefficients are unchanged. Verify this with a following impulse that gives the default response.
